// File: rtl/retire_trace_buffer.sv
// Retirement trace capture: run/halt/timeout FSM feeding a FIFO of retired events.
// Optional macro TRACE_TS_EN adds a per-entry cycle timestamp presented on rd_ts.
module retire_trace_buffer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CYCLE_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              hlt,
    input  logic              reg_we,
    input  logic [3:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [3:0]        rd_flags,
    output logic [3:0]        rd_reg,
    output logic [DATA_W-1:0] rd_rdata,
    output logic [DATA_W-1:0] rd_maddr,
    output logic [DATA_W-1:0] rd_mdata,
    output logic [31:0]       rd_ts,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       inst_cnt,
    output logic [15:0]       drop_cnt,
    output logic              overflow,
    output logic [1:0]        state,
    output logic              done
);

    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned BASE_W = 8 + 3 * DATA_W;
`ifdef TRACE_TS_EN
    localparam int unsigned ENTRY_W = BASE_W + 32;
`else
    localparam int unsigned ENTRY_W = BASE_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [31:0]        cycle_cnt_q, cycle_cnt_d;
    logic [31:0]        inst_cnt_q, inst_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;
    logic               rd_valid_q, rd_valid_d;
    logic               done_q, done_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] entry_d;
    logic [ENTRY_W-1:0] head;

    logic in_run, evt, retire;
    logic full, pop, do_push, drop;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state; halt outranks the cycle limit, both outrank en dropping
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN: begin
                if (hlt)                              state_d = ST_HALTED;
                else if (cycle_cnt_q == 32'(CYCLE_LIMIT)) state_d = ST_TIMEOUT;
                else if (!en)                         state_d = ST_IDLE;
            end
            default: state_d = state_q;
        endcase
    end

    // FSM: outputs
    always_comb begin
        state  = state_q;
        in_run = (state_q == ST_RUN);
        evt    = in_run & (hlt | reg_we | mem_rd | mem_wr);
        retire = in_run & (hlt | reg_we | mem_wr);
    end

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        pop     = rd_valid_q & rd_ready;
        do_push = evt & (~full | pop);
        drop    = evt & full & ~pop;

        entry_d = '0;
        entry_d[BASE_W-1:0] = {hlt, reg_we, mem_rd, mem_wr, reg_addr, reg_data, mem_addr,
                               (mem_wr ? mem_wdata : mem_rdata)};
`ifdef TRACE_TS_EN
        entry_d[BASE_W +: 32] = cycle_cnt_q;
`endif

        wptr_d = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        unique case ({do_push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d  = overflow_q | drop;
        drop_cnt_d  = (drop && drop_cnt_q != '1) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        cycle_cnt_d = (in_run && cycle_cnt_q != '1) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        inst_cnt_d  = retire ? inst_cnt_q + 32'd1 : inst_cnt_q;
        rd_valid_d  = (count_d != '0);
        done_d      = ((state_d == ST_HALTED) || (state_d == ST_TIMEOUT)) && (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever rd_valid is low
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wptr_q] <= entry_d;
    end

    always_comb begin
        head     = rd_valid_q ? mem_q[rptr_q] : '0;
        rd_mdata = head[DATA_W-1:0];
        rd_maddr = head[DATA_W +: DATA_W];
        rd_rdata = head[2*DATA_W +: DATA_W];
        rd_reg   = head[3*DATA_W +: 4];
        rd_flags = head[3*DATA_W+4 +: 4];
`ifdef TRACE_TS_EN
        rd_ts    = head[BASE_W +: 32];
`else
        rd_ts    = '0;
`endif
    end

    assign rd_valid  = rd_valid_q;
    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer (DEPTH=4, CYCLE_LIMIT=20).
module tb_retire_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n, en, hlt, reg_we, mem_rd, mem_wr, rd_ready;
    logic [3:0]  reg_addr;
    logic [15:0] reg_data, mem_addr, mem_wdata, mem_rdata;
    logic        rd_valid, overflow, done;
    logic [3:0]  rd_flags, rd_reg;
    logic [15:0] rd_rdata, rd_maddr, rd_mdata, drop_cnt;
    logic [31:0] rd_ts, cycle_cnt, inst_cnt;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    retire_trace_buffer #(.DATA_W(16), .DEPTH(4), .CYCLE_LIMIT(20)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hlt(hlt), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_data(reg_data), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_flags(rd_flags), .rd_reg(rd_reg),
        .rd_rdata(rd_rdata), .rd_maddr(rd_maddr), .rd_mdata(rd_mdata), .rd_ts(rd_ts),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .drop_cnt(drop_cnt),
        .overflow(overflow), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic we, input logic mr, input logic mw,
                         input logic [3:0] ra, input logic [15:0] rdat, input logic [15:0] ma,
                         input logic [15:0] mwd, input logic [15:0] mrd);
        hlt = h; reg_we = we; mem_rd = mr; mem_wr = mw;
        reg_addr = ra; reg_data = rdat; mem_addr = ma; mem_wdata = mwd; mem_rdata = mrd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_state"},    32'(state), 32'd0);
        check({pfx, "_valid"},    32'(rd_valid), 32'd0);
        check({pfx, "_cycle"},    cycle_cnt, 32'd0);
        check({pfx, "_inst"},     inst_cnt, 32'd0);
        check({pfx, "_drop"},     32'(drop_cnt), 32'd0);
        check({pfx, "_ovf"},      32'(overflow), 32'd0);
        check({pfx, "_done"},     32'(done), 32'd0);
        check({pfx, "_flags"},    32'(rd_flags), 32'd0);
        check({pfx, "_rdata"},    32'(rd_rdata), 32'd0);
        check({pfx, "_mdata"},    32'(rd_mdata), 32'd0);
        check({pfx, "_ts"},       rd_ts, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] drain_exp [4];

    initial begin
        rst_n = 1'b0; en = 1'b0; rd_ready = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        check_reset("rst");

        // reg write then store, consumer always ready
        rd_ready = 1'b1; en = 1'b1;
        step();
        check("run_state", 32'(state), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'h1234, 16'h0, 16'h0, 16'h0);
        step();
        check("e1_valid", 32'(rd_valid), 32'd1);
        check("e1_flags", 32'(rd_flags), 32'b0100);
        check("e1_reg",   32'(rd_reg), 32'd3);
        check("e1_rdata", 32'(rd_rdata), 32'h1234);
        check("e1_inst",  inst_cnt, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0, 16'h0040, 16'hBEEF, 16'h5555);
        step();
        check("e2_flags", 32'(rd_flags), 32'b0001);
        check("e2_maddr", 32'(rd_maddr), 32'h0040);
        check("e2_mdata", 32'(rd_mdata), 32'hBEEF);
        check("e2_inst",  inst_cnt, 32'd2);
        idle();
        step();
        check("e2_popped", 32'(rd_valid), 32'd0);

        // load without reg write: captured, not counted
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 16'h0010, 16'h7777, 16'h00AA);
        step();
        check("ld_flags", 32'(rd_flags), 32'b0010);
        check("ld_mdata", 32'(rd_mdata), 32'h00AA);
        check("ld_inst",  inst_cnt, 32'd2);
`ifdef TRACE_TS_EN
        check("ld_ts", rd_ts, 32'd3);
`else
        check("ld_ts", rd_ts, 32'd0);
`endif
        idle();
        step();

        // simultaneous load and store selects store data
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0, 16'h0020, 16'h1111, 16'h2222);
        step();
        check("rw_flags", 32'(rd_flags), 32'b0011);
        check("rw_mdata", 32'(rd_mdata), 32'h1111);
        check("rw_inst",  inst_cnt, 32'd3);
        idle();
        step();

        // overflow: six events into four slots with consumer stalled
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 16'h00A0 + 16'(i), 16'h0, 16'h0, 16'h0);
            step();
        end
        check("ovf_drop",  32'(drop_cnt), 32'd2);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_inst",  inst_cnt, 32'd9);
        check("ovf_head",  32'(rd_rdata), 32'h00A0);
        check("ovf_hreg",  32'(rd_reg), 32'd0);

        // full with push and pop together
        rd_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 16'h00B0, 16'h0, 16'h0, 16'h0);
        step();
        check("pp_drop", 32'(drop_cnt), 32'd2);
        check("pp_inst", inst_cnt, 32'd10);
        idle();
        drain_exp[0] = 16'h00A1; drain_exp[1] = 16'h00A2;
        drain_exp[2] = 16'h00A3; drain_exp[3] = 16'h00B0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(rd_valid), 32'd1);
            check($sformatf("drain%0d_data", i), 32'(rd_rdata), 32'(drain_exp[i]));
            step();
        end
        check("drain_empty", 32'(rd_valid), 32'd0);
        check("drain_cycle", cycle_cnt, 32'd18);

        // timeout with two entries pending
        rd_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'h00C1, 16'h0, 16'h0, 16'h0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 16'h00C2, 16'h0, 16'h0, 16'h0);
        step();
        check("pre_to_state", 32'(state), 32'd1);
        check("pre_to_cycle", cycle_cnt, 32'd20);
        idle();
        step();
        check("to_state", 32'(state), 32'd3);
        check("to_cycle", cycle_cnt, 32'd21);
        check("to_done",  32'(done), 32'd0);
        check("to_head",  32'(rd_rdata), 32'h00C1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 16'h00DD, 16'h0, 16'h0, 16'h0);
        step();
        check("to_inst",  inst_cnt, 32'd12);
        check("to_cycle_hold", cycle_cnt, 32'd21);
        idle();
        rd_ready = 1'b1;
        step();
        check("to_drain_head", 32'(rd_rdata), 32'h00C2);
        rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset("mid_rst");

        // halt coinciding with the cycle limit; halt wins
        en = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        check("lim_cycle", cycle_cnt, 32'd20);
        check("lim_state", 32'(state), 32'd1);
        rd_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0F0F, 16'h0, 16'h0, 16'h0);
        step();
        check("h_state", 32'(state), 32'd2);
        check("h_cycle", cycle_cnt, 32'd21);
        check("h_flags", 32'(rd_flags), 32'b1100);
        check("h_rdata", 32'(rd_rdata), 32'h0F0F);
        check("h_inst",  inst_cnt, 32'd1);
        check("h_done",  32'(done), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 16'hEEEE, 16'h0, 16'h0, 16'h0);
        step();
        check("h_ign_inst", inst_cnt, 32'd1);
        check("h_stable",   32'(rd_rdata), 32'h0F0F);
        idle();
        rd_ready = 1'b1;
        step();
        check("h_empty", 32'(rd_valid), 32'd0);
        check("h_done1", 32'(done), 32'd1);
        check("h_state2", 32'(state), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
